// File: rtl/siso_tx_ctrl.sv
// siso_tx_ctrl: accepts a word over valid/ready and shifts it out one bit per shift_en
// strobe, with framing, idle gap and done pulse. Define SISO_TX_PARITY_EN for an even-parity bit.
module siso_tx_ctrl #(
   parameter int WIDTH      = 4,
   parameter int GAP_CYCLES = 1,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             shift_en,
   output logic             Dout,
   output logic             frame,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
`ifdef SISO_TX_PARITY_EN
   localparam logic [1:0] PARITY = 2'd2;
`endif
   localparam logic [1:0] GAP   = 2'd3;

   localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WIDTH - 1);
   localparam logic [7:0]       GAP_LAST   = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
   // With no gap configured the controller returns straight to IDLE after the word.
   localparam logic [1:0]       AFTER_WORD = (GAP_CYCLES > 0) ? GAP : IDLE;

   logic [1:0]       state;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sreg_next;
   logic [CNT_W-1:0] bit_cnt;
   logic [7:0]       gap_cnt;
`ifdef SISO_TX_PARITY_EN
   logic             parity;
`endif

   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   assign sreg_next = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         sreg    <= '0;
         bit_cnt <= '0;
         gap_cnt <= '0;
         Dout    <= 1'b0;
         frame   <= 1'b0;
         done    <= 1'b0;
`ifdef SISO_TX_PARITY_EN
         parity  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // The first bit goes out on the accept edge, regardless of shift_en.
               if (in_valid) begin
                  state   <= SHIFT;
                  sreg    <= in_data;
                  bit_cnt <= '0;
                  Dout    <= first_bit(in_data);
                  frame   <= 1'b1;
`ifdef SISO_TX_PARITY_EN
                  parity  <= ^in_data;
`endif
               end
            end
            SHIFT: begin
               if (shift_en) begin
                  if (bit_cnt == LAST_BIT) begin
`ifdef SISO_TX_PARITY_EN
                     state   <= PARITY;
                     Dout    <= parity;
                     frame   <= 1'b1;
`else
                     state   <= AFTER_WORD;
                     Dout    <= 1'b0;
                     frame   <= 1'b0;
                     done    <= 1'b1;
                     gap_cnt <= '0;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     sreg    <= sreg_next;
                     Dout    <= first_bit(sreg_next);
                  end
               end
            end
`ifdef SISO_TX_PARITY_EN
            PARITY: begin
               if (shift_en) begin
                  state   <= AFTER_WORD;
                  Dout    <= 1'b0;
                  frame   <= 1'b0;
                  done    <= 1'b1;
                  gap_cnt <= '0;
               end
            end
`endif
            GAP: begin
               if (shift_en) begin
                  gap_cnt <= gap_cnt + 8'd1;
                  if (gap_cnt == GAP_LAST) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_siso_tx_ctrl.sv
// Bench for siso_tx_ctrl: one instance with a 1-strobe gap, one with no gap; a monitor
// pops expected serial bits from a scoreboard queue as each new framed bit appears.
module tb_siso_tx_ctrl;

   localparam int WIDTH = 4;
`ifdef SISO_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int L = WIDTH + PAR;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_valid = 1'b0;
   logic             shift_en = 1'b0;

   logic in_ready_a, Dout_a, frame_a, busy_a, done_a;
   logic in_ready_b, Dout_b, frame_b, busy_b, done_b;

   int checks = 0;
   int passed = 0;

   logic exp_q[$];
   logic sel_b = 1'b0;
   logic prev_frame = 1'b0, prev_strobe = 1'b0, last_dout = 1'b0;
   int   bits_seen = 0;
   int   done_seen = 0;
   int   done_at_bits = -1;

   siso_tx_ctrl #(.WIDTH(WIDTH), .GAP_CYCLES(1), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_a), .shift_en(shift_en), .Dout(Dout_a), .frame(frame_a),
      .busy(busy_a), .done(done_a));

   siso_tx_ctrl #(.WIDTH(WIDTH), .GAP_CYCLES(0), .MSB_FIRST(1'b1)) dut_b (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_b), .shift_en(shift_en), .Dout(Dout_b), .frame(frame_b),
      .busy(busy_b), .done(done_b));

   always #5 clk = ~clk;

   // A framed bit is new when the frame just opened or a strobe was sampled since the last look.
   always @(negedge clk) begin
      logic f, d, dn, e;
      f  = sel_b ? frame_b : frame_a;
      d  = sel_b ? Dout_b  : Dout_a;
      dn = sel_b ? done_b  : done_a;
      if (dn === 1'b1) begin
         done_seen++;
         done_at_bits = bits_seen;
      end
      if (f === 1'b1) begin
         checks++;
         if (!prev_frame || prev_strobe) begin
            if (exp_q.size() == 0) begin
               $display("FAIL extra_bit: got Dout=%0b, no bit expected", d);
            end else begin
               e = exp_q.pop_front();
               if (d !== e) $display("FAIL serial_bit %0d: got %0b, want %0b", bits_seen, d, e);
               else passed++;
            end
            bits_seen++;
         end else begin
            if (d !== last_dout) $display("FAIL bit_hold: got %0b, want %0b", d, last_dout);
            else passed++;
         end
      end
      prev_frame  = (f === 1'b1);
      prev_strobe = shift_en;
      last_dout   = d;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [WIDTH-1:0] w);
      for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(w[i]);
      if (PAR != 0) exp_q.push_back(^w);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      exp_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; in_data = 4'hF; shift_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({Dout_a, frame_a, busy_a, done_a} !== 4'b0000)
            $display("FAIL reset_outputs cyc %0d: got %b, want 0000", i, {Dout_a, frame_a, busy_a, done_a});
         else passed++;
      end
      reset = 1'b0; in_valid = 1'b0;
      tick();
      checks++;
      if ({in_ready_a, busy_a, frame_a} !== 3'b100)
         $display("FAIL reset_release: got ready/busy/frame=%b, want 100", {in_ready_a, busy_a, frame_a});
      else passed++;
   endtask

   task automatic test_basic();
      int b0, d0;
      sel_b = 1'b0; shift_en = 1'b1;
      b0 = bits_seen; d0 = done_seen;
      push_word(4'b1011);
      in_data = 4'b1011; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < L - 1; i++) tick();
      checks++;
      if (done_a !== 1'b0 || frame_a !== 1'b1)
         $display("FAIL basic_last_bit: got done=%0b frame=%0b, want 0 1", done_a, frame_a);
      else passed++;
      tick();
      checks++;
      if ({done_a, frame_a, Dout_a, in_ready_a, busy_a} !== 5'b10001)
         $display("FAIL basic_done_gap: got %b, want 10001", {done_a, frame_a, Dout_a, in_ready_a, busy_a});
      else passed++;
      tick();
      checks++;
      if ({done_a, in_ready_a, busy_a} !== 3'b010)
         $display("FAIL basic_idle: got %b, want 010", {done_a, in_ready_a, busy_a});
      else passed++;
      checks++;
      if (bits_seen - b0 != L || done_seen - d0 != 1 || exp_q.size() != 0)
         $display("FAIL basic_counts: got bits=%0d done=%0d left=%0d, want %0d 1 0",
                  bits_seen - b0, done_seen - d0, exp_q.size(), L);
      else passed++;
   endtask

   task automatic test_strobed();
      int b0, d0, n;
      bit fin;
      sel_b = 1'b0;
      b0 = bits_seen; d0 = done_seen;
      push_word(4'b0110);
      in_data = 4'b0110; in_valid = 1'b1; shift_en = 1'b0;
      tick();
      in_valid = 1'b0;
      fin = 1'b0;
      n = 0;
      for (int cyc = 0; cyc < 120 && !fin; cyc++) begin
         shift_en = (cyc % 3 == 2);
         tick();
         n++;
         if (!busy_a) fin = 1'b1;
      end
      shift_en = 1'b0;
      checks++;
      if (!fin) $display("FAIL strobed_timeout: busy after %0d cycles, want idle", n);
      else passed++;
      checks++;
      if (bits_seen - b0 != L || done_seen - d0 != 1 || exp_q.size() != 0)
         $display("FAIL strobed_counts: got bits=%0d done=%0d left=%0d, want %0d 1 0",
                  bits_seen - b0, done_seen - d0, exp_q.size(), L);
      else passed++;
      // Last bit sits for 3 clks, parity adds 3 more, gap waits for one strobe (3 clks).
      checks++;
      if (n != 3 * L + 3) $display("FAIL strobed_duration: got %0d clks, want %0d", n, 3 * L + 3);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] hist, mask, want;
      int d0;
      bit take;
      do_reset();
      sel_b = 1'b1; shift_en = 1'b1;
      d0 = done_seen;
      push_word(4'hA);
      push_word(4'h5);
      in_data = 4'hA; in_valid = 1'b1;
      tick();
      in_data = 4'h5;
      hist = '0;
      for (int i = 0; i < 2 * L + 2; i++) begin
         hist = {hist[14:0], frame_b};
         take = in_ready_b;
         tick();
         if (take) in_valid = 1'b0;
      end
      mask = 16'((32'd1 << (2 * L + 2)) - 1);
      want = 16'(((32'd1 << L) - 1) << (L + 2)) | 16'(((32'd1 << L) - 1) << 1);
      checks++;
      if ((hist & mask) !== want) $display("FAIL b2b_frame: got %b, want %b", hist & mask, want);
      else passed++;
      checks++;
      if (done_seen - d0 != 2 || exp_q.size() != 0)
         $display("FAIL b2b_counts: got done=%0d left=%0d, want 2 0", done_seen - d0, exp_q.size());
      else passed++;
      sel_b = 1'b0;
      do_reset();
   endtask

   task automatic test_reset_mid();
      int b0, d0;
      do_reset();
      sel_b = 1'b0; shift_en = 1'b1;
      b0 = bits_seen; d0 = done_seen;
      push_word(4'hC);
      in_data = 4'hC; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      checks++;
      if ({Dout_a, frame_a, busy_a} !== 3'b000)
         $display("FAIL midreset_out: got %b, want 000", {Dout_a, frame_a, busy_a});
      else passed++;
      reset = 1'b0;
      tick();
      checks++;
      if (in_ready_a !== 1'b1) $display("FAIL midreset_ready: got %0b, want 1", in_ready_a);
      else passed++;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (bits_seen - b0 != 2 || done_seen != d0 || exp_q.size() != L - 2)
         $display("FAIL midreset_counts: got bits=%0d done=%0d left=%0d, want 2 0 %0d",
                  bits_seen - b0, done_seen - d0, exp_q.size(), L - 2);
      else passed++;
      exp_q.delete();
   endtask

   task automatic test_frame_length();
      int b0, d0;
      bit fin;
      sel_b = 1'b0; shift_en = 1'b1;
      b0 = bits_seen; d0 = done_seen;
      push_word(4'b0111);
      in_data = 4'b0111; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      fin = 1'b0;
      for (int i = 0; i < 40 && !fin; i++) begin
         tick();
         if (!busy_a) fin = 1'b1;
      end
      checks++;
      if (!fin) $display("FAIL frame_timeout: still busy, want idle");
      else passed++;
      checks++;
      if (bits_seen - b0 != L || done_seen - d0 != 1 || done_at_bits != b0 + L || exp_q.size() != 0)
         $display("FAIL frame_length: got bits=%0d done=%0d done_after=%0d, want %0d 1 %0d",
                  bits_seen - b0, done_seen - d0, done_at_bits - b0, L, L);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_strobed();
      test_back_to_back();
      test_reset_mid();
      test_frame_length();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
